// File: rtl/fifo_rr_arbiter_if.sv
// Handshake/data bundle between the arbiter and the surrounding FIFOs.
//   in_empty     : empty flags of the input FIFOs
//   in_data      : concatenated data_out of the input FIFOs, FIFO i at [DW*i +: DW]
//   in_pop       : one-hot pop to the input FIFOs
//   out_alm_full : almost-full flags of the output FIFOs
//   out_push     : one-hot push to the output FIFOs
//   out_data     : shared data_in bus to the output FIFOs
// master = arbiter side, slave = FIFO side.
interface fifo_rr_arbiter_if #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned NPORT      = 4
);
    logic [NPORT-1:0]            in_empty;
    logic [NPORT*DATA_WIDTH-1:0] in_data;
    logic [NPORT-1:0]            in_pop;
    logic [NPORT-1:0]            out_alm_full;
    logic [NPORT-1:0]            out_push;
    logic [DATA_WIDTH-1:0]       out_data;

    modport master (
        input  in_empty, in_data, out_alm_full,
        output in_pop, out_push, out_data
    );

    modport slave (
        output in_empty, in_data, out_alm_full,
        input  in_pop, out_push, out_data
    );
endinterface

// File: rtl/fifo_rr_arbiter.sv
// Control and drain stage for four input FIFOs: drives their one-hot state and
// thresholds, pops them round-robin and routes each word to the output FIFO
// named by its top two bits, with a one-word hold register for backpressure.
//   clk, reset          : clock, synchronous active-high reset
//   init                : request threshold re-programming (IDLE only)
//   thr_sup, thr_inf    : thresholds to program
//   state               : one-hot RESET/INIT/IDLE/ACTIVE
//   sup_Threshold,
//   inf_Threshold       : registered thresholds
//   idle                : high while state is IDLE
//   bus                 : FIFO handshake/data bundle (master side)
module fifo_rr_arbiter #(
    parameter int unsigned DATA_WIDTH = 10,
    parameter int unsigned NPORT      = 4
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       init,
    input  logic [2:0] thr_sup,
    input  logic [2:0] thr_inf,
    output logic [3:0] state,
    output logic [2:0] sup_Threshold,
    output logic [2:0] inf_Threshold,
    output logic       idle,
    fifo_rr_arbiter_if.master bus
);

    localparam int unsigned PTR_W = 2;

    typedef enum logic [3:0] {
        ST_RESET  = 4'b0001,
        ST_INIT   = 4'b0010,
        ST_IDLE   = 4'b0100,
        ST_ACTIVE = 4'b1000
    } state_t;

    state_t                 state_q, state_d;
    logic                   pend;
    logic [PTR_W-1:0]       pend_src;
    logic                   hold_valid;
    logic [DATA_WIDTH-1:0]  hold_data;
    logic [PTR_W-1:0]       rr;

    logic [DATA_WIDTH-1:0]  in_word [NPORT];
    logic                   cand_valid;
    logic [DATA_WIDTH-1:0]  cand_data;
    logic [PTR_W-1:0]       cand_dest;
    logic                   push_ok;
    logic                   stall;
    logic                   pop_ok;
    logic                   any_req;
    logic                   found;
    logic [PTR_W-1:0]       idx;
    logic [PTR_W-1:0]       grant_idx;

    assign state = 4'(state_q);

    // Split the flat input data bus into per-FIFO words.
    always_comb begin
        for (int unsigned i = 0; i < NPORT; i++) begin
            in_word[i] = bus.in_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
    end

    // Candidate selection, delivery, pop grant and next state.
    always_comb begin
        state_d    = state_q;
        cand_valid = hold_valid | pend;
        cand_data  = '0;
        found      = 1'b0;
        grant_idx  = rr;
        idx        = rr;

        if (hold_valid) begin
            cand_data = hold_data;
        end else if (pend) begin
            cand_data = in_word[pend_src];
        end
        cand_dest = cand_data[DATA_WIDTH-1 -: PTR_W];

        // Reset gating keeps a stale hold word from escaping during the reset cycle.
        push_ok = !reset && cand_valid && (|cand_data) && !bus.out_alm_full[cand_dest];
        stall   = cand_valid && (|cand_data) && !push_ok;
        any_req = ~&bus.in_empty;
        pop_ok  = !reset && (state_q == ST_ACTIVE) && !stall && any_req;

        // First non-empty FIFO searching rr, rr+1, ... modulo NPORT.
        for (int unsigned k = 0; k < NPORT; k++) begin
            idx = rr + PTR_W'(k);
            if (!found && !bus.in_empty[idx]) begin
                found     = 1'b1;
                grant_idx = idx;
            end
        end

        bus.in_pop   = pop_ok  ? (NPORT'(1) << grant_idx) : '0;
        bus.out_push = push_ok ? (NPORT'(1) << cand_dest) : '0;
        bus.out_data = push_ok ? cand_data : '0;

        case (state_q)
            ST_RESET:  state_d = ST_INIT;
            ST_INIT:   state_d = ST_IDLE;
            ST_IDLE: begin
                if (init) begin
                    state_d = ST_INIT;
                end else if (any_req) begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (!any_req && !pend && !hold_valid) begin
                    state_d = ST_IDLE;
                end
            end
            default:   state_d = ST_RESET;
        endcase
    end

    // State, pointer, pending-pop and hold registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= ST_RESET;
            idle          <= 1'b0;
            sup_Threshold <= '0;
            inf_Threshold <= '0;
            pend          <= 1'b0;
            pend_src      <= '0;
            hold_valid    <= 1'b0;
            hold_data     <= '0;
            rr            <= '0;
        end else begin
            state_q <= state_d;
            idle    <= (state_d == ST_IDLE);
            if (state_d == ST_INIT) begin
                sup_Threshold <= thr_sup;
                inf_Threshold <= thr_inf;
            end
            pend <= pop_ok;
            if (pop_ok) begin
                pend_src <= grant_idx;
                rr       <= grant_idx + PTR_W'(1);
            end
            hold_valid <= stall;
            if (stall) begin
                hold_data <= cand_data;
            end
        end
    end

endmodule

// File: tb/tb_fifo_rr_arbiter.sv
module tb_fifo_rr_arbiter;

    logic       clk;
    logic       reset;
    logic       init;
    logic [2:0] thr_sup;
    logic [2:0] thr_inf;
    logic [3:0] state;
    logic [2:0] sup_Threshold;
    logic [2:0] inf_Threshold;
    logic       idle;

    fifo_rr_arbiter_if #(.DATA_WIDTH(10), .NPORT(4)) bus ();

    fifo_rr_arbiter dut (
        .clk           (clk),
        .reset         (reset),
        .init          (init),
        .thr_sup       (thr_sup),
        .thr_inf       (thr_inf),
        .state         (state),
        .sup_Threshold (sup_Threshold),
        .inf_Threshold (inf_Threshold),
        .idle          (idle),
        .bus           (bus.master)
    );

    // Input FIFO model: fill_q is staged writes, q is FIFO contents.
    logic [9:0] fill_q [4][$];
    logic [9:0] q      [4][$];
    logic [9:0] words  [4];
    logic [9:0] sb [$];
    logic [3:0] pop_s;
    int         rr_ref;
    int         cyc;
    int         chk_cnt;
    int         pass_cnt;

    int         pop_log_idx [$];
    int         pop_log_cyc [$];
    int         push_log_cyc [$];
    logic [3:0] push_log_vec [$];
    logic [9:0] push_log_dat [$];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        chk_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic fill(input int port, input logic [9:0] w);
        fill_q[port].push_back(w);
    endtask

    task automatic clear_logs();
        pop_log_idx.delete();
        pop_log_cyc.delete();
        push_log_cyc.delete();
        push_log_vec.delete();
        push_log_dat.delete();
    endtask

    task automatic wait_drain(input int budget, input string name);
        logic done;
        done = 1'b0;
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            done = idle && (sb.size() == 0);
            for (int i = 0; i < 4; i++)
                if (q[i].size() != 0 || fill_q[i].size() != 0) done = 1'b0;
            if (done) break;
        end
        check(name, 32'(done), 32'd1);
    endtask

    // FIFO model: applies pops sampled at the previous negedge and staged fills.
    initial begin
        bus.in_empty = '1;
        bus.in_data  = '0;
        cyc = 0;
        for (int i = 0; i < 4; i++) words[i] = '0;
        forever begin
            @(posedge clk);
            #1;
            if (reset) begin
                for (int i = 0; i < 4; i++) begin
                    q[i].delete();
                    fill_q[i].delete();
                    words[i] = '0;
                end
                sb.delete();
            end else begin
                for (int i = 0; i < 4; i++) begin
                    if (pop_s[i] && q[i].size() > 0) begin
                        words[i] = q[i].pop_front();
                        if (words[i] != 10'd0) sb.push_back(words[i]);
                    end
                end
                for (int i = 0; i < 4; i++)
                    while (fill_q[i].size() > 0) q[i].push_back(fill_q[i].pop_front());
            end
            for (int i = 0; i < 4; i++) begin
                bus.in_empty[i] = (q[i].size() == 0);
                bus.in_data[i*10 +: 10] = words[i];
            end
            cyc++;
        end
    end

    // Monitor: checks every pop against the round-robin rule and every push
    // against the scoreboard of words popped earlier.
    initial begin
        pop_s  = '0;
        rr_ref = 0;
        forever begin
            @(negedge clk);
            pop_s = bus.in_pop;
            if (cyc > 0) begin
                if (reset) rr_ref = 0;
                if (bus.in_pop != 4'd0) begin
                    int g;
                    int p;
                    g = -1;
                    p = 0;
                    for (int k = 0; k < 4; k++) begin
                        if (g < 0 && q[(rr_ref + k) % 4].size() != 0) g = (rr_ref + k) % 4;
                    end
                    for (int i = 0; i < 4; i++) if (bus.in_pop[i]) p = i;
                    check("pop_onehot", 32'($onehot(bus.in_pop)), 32'd1);
                    check("pop_grant", 32'(p), 32'(g));
                    rr_ref = (g + 1) % 4;
                    pop_log_idx.push_back(p);
                    pop_log_cyc.push_back(cyc);
                end
                if (bus.out_push != 4'd0) begin
                    logic [9:0] e;
                    logic [3:0] ev;
                    push_log_cyc.push_back(cyc);
                    push_log_vec.push_back(bus.out_push);
                    push_log_dat.push_back(bus.out_data);
                    if (sb.size() == 0) begin
                        check("push_unexpected", 32'(bus.out_data), 32'd0);
                    end else begin
                        e  = sb.pop_front();
                        ev = 4'(1) << e[9:8];
                        check("push_data", 32'(bus.out_data), 32'(e));
                        check("push_dest", 32'(bus.out_push), 32'(ev));
                    end
                end else begin
                    check("data_zero_no_push", 32'(bus.out_data), 32'd0);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout at cycle %0d", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        logic got;
        chk_cnt  = 0;
        pass_cnt = 0;
        reset    = 1'b1;
        init     = 1'b0;
        thr_sup  = 3'd0;
        thr_inf  = 3'd0;
        bus.out_alm_full = 4'd0;

        // Reset sequence.
        @(posedge clk);
        repeat (3) begin
            @(negedge clk);
            check("rst_state", 32'(state), 32'h1);
            check("rst_outputs", {21'd0, idle, bus.in_pop, bus.out_push, sup_Threshold, inf_Threshold},
                  32'd0);
            check("rst_out_data", 32'(bus.out_data), 32'd0);
        end
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rst_hold_state", 32'(state), 32'h1);
        @(negedge clk);
        check("init_state", 32'(state), 32'h2);
        @(negedge clk);
        check("idle_state", 32'(state), 32'h4);
        check("idle_flag", 32'(idle), 32'd1);

        // Threshold programming.
        tick();
        init = 1'b1;
        thr_sup = 3'd6;
        thr_inf = 3'd2;
        tick();
        init = 1'b0;
        @(negedge clk);
        check("thr_init_state", 32'(state), 32'h2);
        check("thr_sup", 32'(sup_Threshold), 32'd6);
        check("thr_inf", 32'(inf_Threshold), 32'd2);
        check("thr_idle_during_init", 32'(idle), 32'd0);
        @(negedge clk);
        check("thr_back_idle", 32'(state), 32'h4);
        check("thr_sup_kept", 32'(sup_Threshold), 32'd6);

        // Round-robin: two words in each FIFO, no backpressure.
        clear_logs();
        tick();
        for (int r = 0; r < 2; r++)
            for (int i = 0; i < 4; i++)
                fill(i, {2'(3 - i), 4'(r + 1), 4'(i + 1)});
        wait_drain(60, "rr_drain");
        check("rr_pop_count", 32'(pop_log_idx.size()), 32'd8);
        check("rr_push_count", 32'(push_log_cyc.size()), 32'd8);
        if (pop_log_idx.size() == 8 && push_log_cyc.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                check("rr_order", 32'(pop_log_idx[k]), 32'(k % 4));
                check("rr_back_to_back", 32'(pop_log_cyc[k] - pop_log_cyc[0]), 32'(k));
                check("rr_push_latency", 32'(push_log_cyc[k] - pop_log_cyc[k]), 32'd1);
            end
        end

        // Routing and zero-word drop.
        clear_logs();
        tick();
        fill(0, 10'h000);
        fill(2, 10'h1A5);
        wait_drain(60, "route_drain");
        check("route_pop_count", 32'(pop_log_idx.size()), 32'd2);
        check("route_push_count", 32'(push_log_cyc.size()), 32'd1);
        if (pop_log_idx.size() == 2 && push_log_cyc.size() == 1) begin
            check("route_pop0", 32'(pop_log_idx[0]), 32'd0);
            check("route_pop1", 32'(pop_log_idx[1]), 32'd2);
            check("route_no_stall", 32'(pop_log_cyc[1] - pop_log_cyc[0]), 32'd1);
            check("route_vec", 32'(push_log_vec[0]), 32'h2);
            check("route_data", 32'(push_log_dat[0]), 32'h1A5);
        end

        // Backpressure on destination 3.
        tick();
        bus.out_alm_full = 4'b1000;
        fill(1, 10'h3C1);
        fill(1, 10'h055);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.in_pop != 4'd0) begin
                got = 1'b1;
                break;
            end
        end
        check("bp_first_pop_seen", 32'(got), 32'd1);
        check("bp_first_pop", 32'(bus.in_pop), 32'h2);
        repeat (5) begin
            @(negedge clk);
            check("bp_hold_no_pop", 32'(bus.in_pop), 32'd0);
            check("bp_hold_no_push", 32'(bus.out_push), 32'd0);
        end
        tick();
        bus.out_alm_full = 4'b0000;
        @(negedge clk);
        check("bp_release_push", 32'(bus.out_push), 32'h8);
        check("bp_release_data", 32'(bus.out_data), 32'h3C1);
        check("bp_resume_pop", 32'(bus.in_pop), 32'h2);
        wait_drain(60, "bp_drain");

        // Reset while a word is held.
        tick();
        bus.out_alm_full = 4'b0001;
        fill(0, 10'h0AA);
        got = 1'b0;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (bus.in_pop != 4'd0) begin
                got = 1'b1;
                break;
            end
        end
        check("rh_pop_seen", 32'(got), 32'd1);
        @(negedge clk);
        check("rh_held", 32'(bus.out_push), 32'd0);
        tick();
        reset = 1'b1;
        bus.out_alm_full = 4'b0000;
        @(negedge clk);
        check("rh_no_push_in_reset", 32'(bus.out_push), 32'd0);
        check("rh_no_data_in_reset", 32'(bus.out_data), 32'd0);
        tick();
        reset = 1'b0;
        @(negedge clk);
        check("rh_state_reset", 32'(state), 32'h1);
        check("rh_no_push_after", 32'(bus.out_push), 32'd0);
        wait_drain(20, "rh_recover");

        // Randomised traffic with random backpressure.
        for (int c = 0; c < 500; c++) begin
            tick();
            for (int i = 0; i < 4; i++) bus.out_alm_full[i] = ($urandom_range(0, 4) == 0);
            if ($urandom_range(0, 9) < 5) begin
                logic [9:0] w;
                w = ($urandom_range(0, 9) == 0) ? 10'd0 : 10'($urandom_range(1, 1023));
                fill(int'($urandom_range(0, 3)), w);
            end
        end
        tick();
        bus.out_alm_full = 4'd0;
        wait_drain(2000, "rand_drain");
        check("rand_sb_empty", 32'(sb.size()), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

endmodule
